data_capture_buffer: RTL and testbench

Parametrised multi-channel capture buffer for the LVDS data-read path. It accepts one CHANNELS-bit sample per valid cycle and packs each channel's bits into 32-bit words in a circular per-channel RAM. An arm/pretrigger/trigger state machine controls capture. After capture, the host reads the record as trigger-aligned 32-bit words per channel.

---
 rtl/data_capture_buffer.sv | 179 +++++++++++++++++
 tb/tb_data_capture_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_capture_buffer.sv
// Multi-channel LVDS capture buffer. Samples are packed LSB-first into 32-bit words
// in per-channel circular RAMs under arm/pretrigger/trigger control; reads are trigger-aligned.

module dcb_lane #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          smp_en,
  input  logic [4:0]    bit_idx,
  input  logic          din,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_word
);
  localparam int NW = 1 << AW;

  logic [31:0] shreg_q, shreg_d;
  logic [31:0] mem [NW];

  always_comb begin
    shreg_d = shreg_q;
    if (smp_en) shreg_d[bit_idx] = din;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;

  // The write takes shreg_d so the sample arriving with bit 31 lands in the same word.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= shreg_d;

  assign rd_word = mem[rd_addr];
endmodule

module data_capture_buffer #(
  parameter  int CHANNELS   = 4,
  parameter  int DEPTH_LOG2 = 13,
  localparam int AW         = DEPTH_LOG2 - 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_data,
  input  logic                in_valid,
  input  logic                arm,
  input  logic [AW-1:0]       pre_words,
  input  logic                trigger,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       trig_word,
  output logic [4:0]          trig_bit,
  input  logic [AW-1:0]       rd_addr,
  input  logic [3:0]          rd_ch,
  output logic [31:0]         rd_data
);
  localparam int           NW   = 1 << AW;
  localparam logic [AW:0]  NW_W = (AW+1)'(NW);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [AW-1:0] pre_lat_q, pre_lat_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW:0]   post_cnt_q, post_cnt_d;
  logic [AW-1:0] trig_word_q, trig_word_d;
  logic [4:0]    trig_bit_q, trig_bit_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          capturing, smp_acc, word_wr;
  logic [AW:0]   post_tgt;
  logic [AW-1:0] rd_phys;
  logic [CHANNELS-1:0][31:0] lane_rd;

  // arm suppresses the sample and any word write of its own cycle
  assign capturing = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign smp_acc   = in_valid && capturing && !arm;
  assign word_wr   = smp_acc && (bitcnt_q == 5'd31);
  assign post_tgt  = NW_W - {1'b0, pre_lat_q};
  assign rd_phys   = start_q + rd_addr;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    bitcnt_d    = bitcnt_q;
    wcnt_d      = wcnt_q;
    pre_lat_d   = pre_lat_q;
    start_d     = start_q;
    post_cnt_d  = post_cnt_q;
    trig_word_d = trig_word_q;
    trig_bit_d  = trig_bit_q;
    if (arm) begin
      state_d    = S_FILL;
      wptr_d     = '0;
      bitcnt_d   = '0;
      wcnt_d     = '0;
      post_cnt_d = '0;
      pre_lat_d  = pre_words;
    end else begin
      if (smp_acc) bitcnt_d = bitcnt_q + 5'd1;
      if (word_wr) begin
        wptr_d = wptr_q + 1'b1;
        if (wcnt_q != NW_W) wcnt_d = wcnt_q + 1'b1;
      end
      case (state_q)
        S_FILL: if (wcnt_q >= {1'b0, pre_lat_q}) state_d = S_WAIT;
        S_WAIT: if (trigger && in_valid) begin
          trig_bit_d = bitcnt_q;
          start_d    = wptr_q - pre_lat_q;
          // trigger word sits pre_lat words after the record start
          trig_word_d = pre_lat_q;
          post_cnt_d  = word_wr ? (AW+1)'(1) : '0;
          state_d     = (word_wr && post_tgt == (AW+1)'(1)) ? S_DONE : S_POST;
        end
        S_POST: if (word_wr) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q + 1'b1 == post_tgt) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (rd_ch == 4'(c)) rd_data_d = lane_rd[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      bitcnt_q    <= '0;
      wcnt_q      <= '0;
      pre_lat_q   <= '0;
      start_q     <= '0;
      post_cnt_q  <= '0;
      trig_word_q <= '0;
      trig_bit_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      bitcnt_q    <= bitcnt_d;
      wcnt_q      <= wcnt_d;
      pre_lat_q   <= pre_lat_d;
      start_q     <= start_d;
      post_cnt_q  <= post_cnt_d;
      trig_word_q <= trig_word_d;
      trig_bit_q  <= trig_bit_d;
      rd_data_q   <= rd_data_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    dcb_lane #(.AW(AW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .smp_en  (smp_acc),
      .bit_idx (bitcnt_q),
      .din     (in_data[c]),
      .wr_en   (word_wr),
      .wr_addr (wptr_q),
      .rd_addr (rd_phys),
      .rd_word (lane_rd[c])
    );
  end

  assign busy      = capturing;
  assign done      = (state_q == S_DONE);
  assign trig_word = trig_word_q;
  assign trig_bit  = trig_bit_q;
  assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_data_capture_buffer.sv
// Bench for data_capture_buffer: scenario table of captures, read-back scoreboard
// against a sample-history model, plus reset and re-arm sequences.

module tb_data_capture_buffer;
  localparam int CH = 4, DL2 = 8, AW = 3, NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] in_data;
  logic          in_valid, arm, trigger;
  logic [AW-1:0] pre_words, rd_addr;
  logic [3:0]    rd_ch;
  logic          busy, done;
  logic [AW-1:0] trig_word;
  logic [4:0]    trig_bit;
  logic [31:0]   rd_data;

  always #5 clk = ~clk;

  data_capture_buffer #(.CHANNELS(CH), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .arm(arm),
    .pre_words(pre_words), .trigger(trigger), .busy(busy), .done(done),
    .trig_word(trig_word), .trig_bit(trig_bit), .rd_addr(rd_addr), .rd_ch(rd_ch),
    .rd_data(rd_data)
  );

  int n_tests = 0, n_fail = 0;
  logic [3:0] samp [1024];

  typedef struct {
    int pre; int trig_at; bit gaps; bit rearm;
    int exp_tw; int exp_tb; int exp_total;
  } scen_t;

  logic [31:0] exp_q [$];
  string       nm_q  [$];
  logic        rd_issue;
  logic        rd_chk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_chk <= rd_issue;

  always @(negedge clk) begin
    if (rd_chk === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk(nm_q.pop_front(), rd_data, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] model_word(input int ch, input int absw);
    logic [31:0] w;
    logic [3:0]  s;
    w = '0;
    if (ch >= CH) return '0;
    for (int k = 0; k < 32; k++) begin
      s = samp[absw*32 + k];
      w[k] = s[ch];
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic issue_read(input int c, input int a, input logic [31:0] e, input string nm);
    tick;
    rd_ch = 4'(c); rd_addr = AW'(a); rd_issue = 1'b1;
    exp_q.push_back(e); nm_q.push_back(nm);
  endtask

  task automatic end_reads;
    tick; rd_issue = 1'b0; tick; tick;
  endtask

  // Arm cycle, then one FILL cycle with no valid data.
  task automatic do_arm(input int p, input logic v, input logic t, input string nm);
    arm = 1'b1; pre_words = AW'(p); in_valid = v; trigger = t; in_data = '1;
    tick;
    arm = 1'b0; in_valid = 1'b0; trigger = 1'b0;
    @(negedge clk); chk({nm, " busy_after_arm"}, 32'(busy), 32'd1);
    tick;
  endtask

  task automatic run_scen(input scen_t sc, input int idx);
    string nm;
    bit    early;
    int    tw_abs;
    nm = $sformatf("s%0d", idx);
    if (sc.rearm) begin
      do_arm(0, 1'b0, 1'b0, {nm, " prerun"});
      for (int s = 0; s < 100; s++) begin
        in_valid = 1'b1; in_data = ~samp[s]; trigger = (s == 0);
        tick;
      end
    end
    do_arm(sc.pre, sc.rearm, sc.rearm, nm);
    early = 1'b0;
    for (int s = 0; s < sc.exp_total; s++) begin
      in_valid = 1'b1; in_data = samp[s];
      trigger = (s == sc.trig_at) || (!sc.gaps && sc.pre > 0 && s == sc.pre*32);
      tick;
      in_valid = 1'b0; trigger = 1'b0;
      @(negedge clk);
      if (s < sc.exp_total-1) begin
        if (done || !busy) early = 1'b1;
      end else begin
        chk({nm, " done_at_end"}, 32'(done), 32'd1);
        chk({nm, " busy_at_end"}, 32'(busy), 32'd0);
      end
      if (sc.gaps) tick;
    end
    chk({nm, " early_done"}, 32'(early), 32'd0);
    chk({nm, " trig_word"}, 32'(trig_word), 32'(sc.exp_tw));
    chk({nm, " trig_bit"}, 32'(trig_bit), 32'(sc.exp_tb));
    tw_abs = sc.trig_at / 32;
    for (int c = 0; c <= CH; c++)
      for (int j = 0; j < NW; j++)
        issue_read(c, j, model_word(c, tw_abs - sc.pre + j),
                   $sformatf("%s rd ch%0d a%0d", nm, c, j));
    issue_read(5, 0, 32'h0, {nm, " rd ch5"});
    end_reads();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t tbl [5];
    int ws;
    tbl[0] = '{pre:0, trig_at:0,   gaps:0, rearm:0, exp_tw:0, exp_tb:0,  exp_total:256};
    tbl[1] = '{pre:3, trig_at:647, gaps:0, rearm:0, exp_tw:3, exp_tb:7,  exp_total:800};
    tbl[2] = '{pre:3, trig_at:647, gaps:1, rearm:0, exp_tw:3, exp_tb:7,  exp_total:800};
    tbl[3] = '{pre:2, trig_at:127, gaps:0, rearm:0, exp_tw:2, exp_tb:31, exp_total:288};
    tbl[4] = '{pre:7, trig_at:264, gaps:0, rearm:1, exp_tw:7, exp_tb:8,  exp_total:288};

    // ch0: word n holds n; ch1: random; ch2: fixed pattern; ch3: all ones
    for (int s = 0; s < 1024; s++) begin
      ws = s / 32;
      samp[s][0] = ws[s % 32];
      samp[s][1] = 1'($urandom);
      samp[s][2] = 1'((s & 1) ^ ((s >> 2) & 1));
      samp[s][3] = 1'b1;
    end

    rst = 1'b1; in_data = '0; in_valid = 1'b0; arm = 1'b0; trigger = 1'b0;
    pre_words = '0; rd_addr = '0; rd_ch = '0; rd_issue = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst done",      32'(done),      32'd0);
    chk("rst trig_word", 32'(trig_word), 32'd0);
    chk("rst trig_bit",  32'(trig_bit),  32'd0);
    chk("rst rd_data",   rd_data,        32'd0);
    tick; rst = 1'b0;
    tick;

    for (int i = 0; i < 5; i++) run_scen(tbl[i], i);

    // Asynchronous reset in the middle of POST
    do_arm(0, 1'b0, 1'b0, "mid_rst");
    rd_ch = 4'd3; rd_addr = '0;
    for (int s = 0; s < 50; s++) begin
      in_valid = 1'b1; in_data = samp[s]; trigger = (s == 0);
      tick;
    end
    @(negedge clk);
    chk("mid_rst busy_before",    32'(busy), 32'd1);
    chk("mid_rst rd_data_before", rd_data,   32'hFFFF_FFFF);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst busy",    32'(busy), 32'd0);
    chk("mid_rst done",    32'(done), 32'd0);
    chk("mid_rst rd_data", rd_data,   32'd0);
    in_data = '0; in_valid = 1'b1; trigger = 1'b1;
    tick; rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; trigger = i[0];
      tick;
    end
    in_valid = 1'b0; trigger = 1'b0;
    @(negedge clk);
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst done", 32'(done), 32'd0);
    for (int j = 0; j < NW; j++)
      issue_read(3, j, 32'hFFFF_FFFF, $sformatf("post_rst rd ch3 a%0d", j));
    end_reads();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
